// File: rtl/object_buffer.sv
// object_buffer
//   Entry FIFO between the table-entry fetch stage and the serializer.
//   Each accepted TABLE_ENTRY is stored together with its table-nesting
//   depth and an end-of-message flag. Entries are presented in order.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   reset      : synchronous active-low reset
//   ob_valid   : fetch presents a valid entry
//   entry      : [127:64] header (bit 64 = nested flag), [63:0] child pointer
//   ob_full    : buffer cannot accept; fetch holds its entry while high
//   out_valid  : head entry is available
//   out_ready  : serializer consumes the head this cycle
//   out_entry  : head entry, unmodified
//   out_depth  : nesting depth tag of the head entry
//   out_last   : head entry is the end-of-message marker
//   count      : current occupancy
//   nest_err   : sticky nesting-overflow flag, cleared only by reset
module object_buffer #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned NEST_W = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ob_valid,
  input  logic [127:0]             entry,
  output logic                     ob_full,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [127:0]             out_entry,
  output logic [NEST_W-1:0]        out_depth,
  output logic                     out_last,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     nest_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0]       FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [NEST_W-1:0] NEST_MAX = '1;

  // Storage (no reset: contents are don't-care until written)
  logic [127:0]      r_mem_entry [DEPTH];
  logic [NEST_W-1:0] r_mem_depth [DEPTH];
  logic [DEPTH-1:0]  r_mem_last;

  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic [NEST_W-1:0] r_nest;
  logic              r_nest_err;

  logic              w_full;
  logic              w_valid;
  logic              w_push;
  logic              w_pop;
  logic              w_hdr_zero;
  logic              w_hdr_nested;
  logic [NEST_W-1:0] w_tag_depth;
  logic              w_tag_last;
  logic [NEST_W-1:0] w_nest_nxt;
  logic              w_nest_ovf;

  // Flags decode only from the registered count
  assign w_full  = (r_count == FULL_CNT);
  assign w_valid = (r_count != '0);
  assign w_push  = ob_valid && !w_full;
  assign w_pop   = w_valid && out_ready;

  assign w_hdr_zero   = (entry[127:64] == '0);
  assign w_hdr_nested = entry[64];

  // Tag and next nesting level for the entry being offered
  always_comb begin
    w_tag_depth = r_nest;
    w_tag_last  = 1'b0;
    w_nest_nxt  = r_nest;
    w_nest_ovf  = 1'b0;
    if (w_hdr_zero) begin
      w_tag_last = (r_nest == '0);
      if (r_nest != '0) begin
        w_nest_nxt = r_nest - NEST_W'(1);
      end
    end else if (w_hdr_nested) begin
      if (r_nest == NEST_MAX) begin
        w_nest_ovf = 1'b1;
      end else begin
        w_nest_nxt = r_nest + NEST_W'(1);
      end
    end
  end

  // Control state
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_nest     <= '0;
      r_nest_err <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
        r_nest   <= w_nest_nxt;
        if (w_nest_ovf) begin
          r_nest_err <= 1'b1;
        end
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage write; an entry offered during a reset cycle is dropped
  always_ff @(posedge clk) begin
    if (reset && w_push) begin
      r_mem_entry[r_wr_ptr] <= entry;
      r_mem_depth[r_wr_ptr] <= w_tag_depth;
      r_mem_last[r_wr_ptr]  <= w_tag_last;
    end
  end

  assign ob_full   = w_full;
  assign out_valid = w_valid;
  assign out_entry = r_mem_entry[r_rd_ptr];
  assign out_depth = r_mem_depth[r_rd_ptr];
  assign out_last  = r_mem_last[r_rd_ptr];
  assign count     = r_count;
  assign nest_err  = r_nest_err;

endmodule

// File: tb/tb_object_buffer.sv
module tb_object_buffer;

  localparam int DEPTH  = 8;
  localparam int NEST_W = 4;
  localparam int NMAX   = (1 << NEST_W) - 1;

  logic                  clk;
  logic                  reset;
  logic                  ob_valid;
  logic [127:0]          entry;
  logic                  ob_full;
  logic                  out_valid;
  logic                  out_ready;
  logic [127:0]          out_entry;
  logic [NEST_W-1:0]     out_depth;
  logic                  out_last;
  logic [$clog2(DEPTH):0] count;
  logic                  nest_err;

  object_buffer #(.DEPTH(DEPTH), .NEST_W(NEST_W)) dut (
    .clk(clk), .reset(reset), .ob_valid(ob_valid), .entry(entry),
    .ob_full(ob_full), .out_valid(out_valid), .out_ready(out_ready),
    .out_entry(out_entry), .out_depth(out_depth), .out_last(out_last),
    .count(count), .nest_err(nest_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [127:0] e;
    int           depth;
    bit           last;
  } exp_t;

  exp_t q[$];
  int   m_nest = 0;
  bit   m_err  = 0;
  bit   started = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tag an accepted entry from the nesting rules
  task automatic model_push(input logic [127:0] e);
    exp_t x;
    logic [63:0] hdr;
    hdr = e[127:64];
    x.e = e;
    x.depth = m_nest;
    x.last = 0;
    if (hdr == 64'd0) begin
      x.last = (m_nest == 0);
      if (m_nest > 0) m_nest = m_nest - 1;
    end else if (hdr[0]) begin
      if (m_nest == NMAX) m_err = 1;
      else m_nest = m_nest + 1;
    end
    q.push_back(x);
  endtask

  // Monitor / scoreboard, sampled on the falling edge
  always @(negedge clk) begin
    if (started && reset) begin
      chk("count", 128'(count), 128'(q.size()));
      chk("out_valid", 128'(out_valid), 128'(q.size() != 0));
      chk("ob_full", 128'(ob_full), 128'(q.size() == DEPTH));
      chk("nest_err", 128'(nest_err), 128'(m_err));
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL pop_empty: got pop expected none at %0t", $time);
        end else begin
          chk("out_entry", out_entry, q[0].e);
          chk("out_depth", 128'(out_depth), 128'(q[0].depth));
          chk("out_last", 128'(out_last), 128'(q[0].last));
          void'(q.pop_front());
        end
      end
      if (ob_valid && !ob_full) model_push(entry);
    end
    if (reset === 1'b0) begin
      started = 1;
      q.delete();
      m_nest = 0;
      m_err = 0;
    end
  end

  function automatic logic [127:0] mk(input logic [63:0] hdr, input logic [63:0] ptr);
    return {hdr, ptr};
  endfunction

  function automatic logic [127:0] rand_entry();
    logic [63:0] hdr;
    int k;
    k = $urandom_range(0, 3);
    hdr = {$urandom, $urandom};
    if (k == 0) hdr = '0;
    else if (k == 1) hdr[0] = 1'b1;
    else begin
      hdr[0] = 1'b0;
      if (hdr == '0) hdr = 64'd2;
    end
    return {hdr, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present e and wait until it is accepted; ob_valid stays high
  task automatic push_one(input logic [127:0] e);
    bit acc;
    ob_valid = 1'b1;
    entry = e;
    acc = 0;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = !ob_full;
      tick();
    end
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL push_timeout: got not accepted expected accepted at %0t", $time);
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 100 && q.size() != 0; i++) tick();
    chk("drain_empty", 128'(q.size()), 128'(0));
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  initial begin
    ob_valid = 1'b0;
    entry = '0;
    out_ready = 1'b0;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    chk("rst_count", 128'(count), 128'(0));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_ob_full", 128'(ob_full), 128'(0));
    chk("rst_nest_err", 128'(nest_err), 128'(0));

    // Three entries, then drain in order
    push_one(mk(64'h11, 64'hA));
    push_one(mk(64'h22, 64'hB));
    push_one(mk(64'h33, 64'hC));
    ob_valid = 1'b0;
    @(negedge clk);
    chk("s1_count", 128'(count), 128'(3));
    chk("s1_head", 128'(out_entry[127:64]), 128'(64'h11));
    tick();
    drain();

    // Fill, hold a ninth entry, pop one, ninth accepted once
    do_reset();
    for (int i = 0; i < DEPTH; i++) push_one(mk(64'(16'h100 + i), 64'(i)));
    ob_valid = 1'b1;
    entry = mk(64'h900, 64'h9);
    @(negedge clk);
    chk("s2_full", 128'(ob_full), 128'(1));
    tick();
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    push_one(mk(64'h900, 64'h9));
    ob_valid = 1'b0;
    tick();
    drain();

    // Nesting sequence
    do_reset();
    push_one(mk(64'h10, 64'h0));
    push_one(mk(64'h21, 64'h1000));
    push_one(mk(64'h30, 64'h0));
    push_one(mk(64'h0, 64'h0));
    push_one(mk(64'h0, 64'h0));
    ob_valid = 1'b0;
    drain();

    // Simultaneous push/pop across pointer wrap at count 4
    do_reset();
    for (int i = 0; i < 4; i++) push_one(rand_entry());
    ob_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      ob_valid = 1'b1;
      entry = mk(64'(32'h400 + 2 * i), {$urandom, $urandom});
      @(negedge clk);
      chk("s4_count", 128'(count), 128'(4));
      tick();
    end
    ob_valid = 1'b0;
    drain();

    // Nesting overflow, sticky error, reset clears it
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) push_one(mk(64'h5, 64'(i)));
    ob_valid = 1'b0;
    chk("s5_nest_err", 128'(nest_err), 128'(1));
    push_one(mk(64'h0, 64'h0));
    ob_valid = 1'b0;
    tick();
    chk("s5_nest_err_sticky", 128'(nest_err), 128'(1));
    out_ready = 1'b0;
    do_reset();
    chk("s5_rst_count", 128'(count), 128'(0));
    chk("s5_rst_nest_err", 128'(nest_err), 128'(0));
    chk("s5_rst_out_valid", 128'(out_valid), 128'(0));

    // Zero header at depth 0, then reset mid-stream
    push_one(mk(64'h0, 64'h0));
    push_one(mk(64'h0, 64'h0));
    for (int i = 0; i < 3; i++) push_one(mk(64'(16'h700 + 2 * i), 64'(i)));
    ob_valid = 1'b0;
    chk("s6_count5", 128'(count), 128'(5));
    ob_valid = 1'b1;
    entry = mk(64'hDEAD0, 64'h1);
    do_reset();
    ob_valid = 1'b0;
    chk("s6_rst_out_valid", 128'(out_valid), 128'(0));
    push_one(mk(64'h800, 64'h8));
    ob_valid = 1'b0;
    drain();

    // Random traffic with held entries under backpressure
    do_reset();
    begin
      bit acc;
      for (int c = 0; c < 400; c++) begin
        @(negedge clk);
        acc = ob_valid && !ob_full;
        tick();
        if (!ob_valid || acc) begin
          ob_valid = ($urandom_range(0, 1) == 1);
          entry = rand_entry();
        end
        out_ready = ($urandom_range(0, 3) != 0);
      end
    end
    ob_valid = 1'b0;
    tick();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
